// File: rtl/nf_debounce.sv
// nf_debounce: synchronise, optionally invert and debounce WIDTH raw inputs, with press/release pulses.
module nf_debounce #(
  parameter int WIDTH = 8,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] INVERT = '0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] in_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic tick_q, tick_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] db_q, db_d, rise_q, rise_d, fall_q, fall_d, s;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    pre_d = pre_q == PRE_MAX ? '0 : pre_q + 1'b1;
    tick_d = pre_q == PRE_MAX;
    sync_d = {sync_q[SYNC_STAGES-2:0], in_raw ^ INVERT};
  end

  // Any cycle where the synchronised input matches the accepted level discards progress.
  always_comb begin
    db_d = db_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == db_q[i]) cnt_d[i] = '0;
      else if (tick_q && cnt_q[i] == CNT_MAX) begin
        db_d[i] = s[i];
        cnt_d[i] = '0;
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else if (tick_q) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_q <= '0;
      tick_q <= 1'b0;
      sync_q <= {SYNC_STAGES{RST_VAL}};
      db_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      tick_q <= tick_d;
      sync_q <= sync_d;
      db_q <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_db = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign tick = tick_q;
endmodule
